// File: rtl/dobby_pkg.sv
// Shared definitions for the dobby bus-to-SRAM slave.
// Holds the bus size codes and the FSM state encoding.
package dobby_pkg;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_RSV = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACCESS,
    CAPTURE,
    RESP
  } state_e;

endpackage

// File: rtl/dobby_lane_align.sv
// Byte-lane steering between the right-aligned core bus and the 32-bit SRAM:
// store replication, byte enables, load lane select and misalignment detect.
module dobby_lane_align
  import dobby_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  output logic [31:0] load_data_o,
  output logic        misalign_o
);

  logic [31:0] rshift;

  always_comb begin
    wdata_o     = store_data_i;
    be_o        = 4'b1111;
    load_data_o = rdata_i;
    misalign_o  = 1'b0;
    rshift      = rdata_i >> {addr_lo_i, 3'b000};
    case (size_i)
      SIZE_B: begin
        wdata_o     = {4{store_data_i[7:0]}};
        be_o        = 4'b0001 << addr_lo_i;
        load_data_o = {24'h0, rshift[7:0]};
      end
      SIZE_H: begin
        wdata_o     = {2{store_data_i[15:0]}};
        be_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        load_data_o = {16'h0, (addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0])};
        misalign_o  = addr_lo_i[0];
      end
      SIZE_W: begin
        misalign_o  = |addr_lo_i;
      end
      default: begin
        misalign_o  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dobby_bus_mem.sv
// dobby core bus slave backed by a synchronous single-port SRAM, with a
// programmable number of wait states ahead of every SRAM access.
module dobby_bus_mem
  import dobby_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int MEM_AW      = 14
) (
  input  logic              clk,
  input  logic              a_reset_l,
  input  logic              i_bus_en,
  input  logic              i_bus_wen,
  input  logic [1:0]        i_bus_size,
  input  logic [15:0]       i_bus_addr,
  input  logic [31:0]       i_store_data,
  output logic              o_bus_ready,
  output logic              o_bus_err,
  output logic [31:0]       o_load_data,
  output logic              o_sram_cs,
  output logic              o_sram_we,
  output logic [3:0]        o_sram_be,
  output logic [MEM_AW-1:0] o_sram_addr,
  output logic [31:0]       o_sram_wdata,
  input  logic [31:0]       i_sram_rdata
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        wen_q;
  logic [1:0]  size_q;
  logic [15:0] addr_q;
  logic [31:0] data_q;

  logic        ready_q, berr_q, cs_q, we_q;
  logic [31:0] ld_q, wdata_q;
  logic [3:0]  be_q;
  logic [MEM_AW-1:0] saddr_q;

  // In IDLE the live bus request feeds the lane logic so a zero-wait access
  // can be set up on the same edge that latches the request.
  logic        idle, cur_wen;
  logic [1:0]  cur_size;
  logic [15:0] cur_addr;
  logic [31:0] cur_data;
  logic [31:0] al_wdata, al_ldata;
  logic [3:0]  al_be;
  logic        al_misalign;

  assign idle     = (state_q == IDLE);
  assign cur_wen  = idle ? i_bus_wen    : wen_q;
  assign cur_size = idle ? i_bus_size   : size_q;
  assign cur_addr = idle ? i_bus_addr   : addr_q;
  assign cur_data = idle ? i_store_data : data_q;

  dobby_lane_align u_align (
    .size_i       (cur_size),
    .addr_lo_i    (cur_addr[1:0]),
    .store_data_i (cur_data),
    .rdata_i      (i_sram_rdata),
    .wdata_o      (al_wdata),
    .be_o         (al_be),
    .load_data_o  (al_ldata),
    .misalign_o   (al_misalign)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (i_bus_en) begin
        err_d = al_misalign;
        if (al_misalign)  state_d = RESP;
        else if (WS != 0) begin
          state_d = WAIT;
          cnt_d   = WS;
        end else          state_d = ACCESS;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ACCESS;
      end
      ACCESS:  state_d = wen_q ? RESP : CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge a_reset_l) begin
    if (!a_reset_l) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      wen_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      berr_q  <= 1'b0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      saddr_q <= '0;
      wdata_q <= '0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (idle && i_bus_en) begin
        wen_q  <= i_bus_wen;
        size_q <= i_bus_size;
        addr_q <= i_bus_addr;
        data_q <= i_store_data;
      end
      // Outputs are registered off the next state so each strobe lines up
      // with the cycle the FSM spends in that state.
      ready_q <= (state_d == RESP);
      berr_q  <= (state_d == RESP) && err_d;
      cs_q    <= (state_d == ACCESS);
      we_q    <= (state_d == ACCESS) && cur_wen;
      if (state_d == ACCESS) begin
        be_q    <= al_be;
        saddr_q <= cur_addr[MEM_AW+1:2];
        wdata_q <= al_wdata;
      end
      if (state_q == CAPTURE)
        ld_q <= al_ldata;
      else if (idle && i_bus_en && al_misalign && !i_bus_wen)
        ld_q <= '0;
    end
  end

  assign o_bus_ready  = ready_q;
  assign o_bus_err    = berr_q;
  assign o_load_data  = ld_q;
  assign o_sram_cs    = cs_q;
  assign o_sram_we    = we_q;
  assign o_sram_be    = be_q;
  assign o_sram_addr  = saddr_q;
  assign o_sram_wdata = wdata_q;

endmodule

// File: tb/tb_dobby_bus_mem.sv
// Scoreboard bench for dobby_bus_mem: a one-wait-state instance for the
// directed accesses and reset aborts, a zero-wait instance for back-to-back.
module tb_dobby_bus_mem;
  import dobby_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_l;

  logic        en1, wen1, rdy1, err1, cs1, we1;
  logic [1:0]  sz1;
  logic [15:0] ad1;
  logic [31:0] sd1, ld1, wd1, rd1;
  logic [3:0]  be1;
  logic [13:0] sa1;

  logic        en0, wen0, rdy0, err0, cs0, we0;
  logic [1:0]  sz0;
  logic [15:0] ad0;
  logic [31:0] sd0, ld0, wd0, rd0;
  logic [3:0]  be0;
  logic [13:0] sa0;

  dobby_bus_mem #(.WAIT_STATES(1), .MEM_AW(14)) dut1 (
    .clk(clk), .a_reset_l(rst_l), .i_bus_en(en1), .i_bus_wen(wen1),
    .i_bus_size(sz1), .i_bus_addr(ad1), .i_store_data(sd1),
    .o_bus_ready(rdy1), .o_bus_err(err1), .o_load_data(ld1),
    .o_sram_cs(cs1), .o_sram_we(we1), .o_sram_be(be1), .o_sram_addr(sa1),
    .o_sram_wdata(wd1), .i_sram_rdata(rd1));

  dobby_bus_mem #(.WAIT_STATES(0), .MEM_AW(14)) dut0 (
    .clk(clk), .a_reset_l(rst_l), .i_bus_en(en0), .i_bus_wen(wen0),
    .i_bus_size(sz0), .i_bus_addr(ad0), .i_store_data(sd0),
    .o_bus_ready(rdy0), .o_bus_err(err0), .o_load_data(ld0),
    .o_sram_cs(cs0), .o_sram_we(we0), .o_sram_be(be0), .o_sram_addr(sa0),
    .o_sram_wdata(wd0), .i_sram_rdata(rd0));

  // SRAM models: synchronous, byte-enabled, read data one cycle after cs.
  logic [31:0] mem1 [0:63];
  logic [31:0] mem0 [0:63];
  always @(posedge clk) if (cs1) begin
    for (int b = 0; b < 4; b++) if (we1 && be1[b]) mem1[sa1[5:0]][8*b +: 8] <= wd1[8*b +: 8];
    rd1 <= mem1[sa1[5:0]];
  end
  always @(posedge clk) if (cs0) begin
    for (int b = 0; b < 4; b++) if (we0 && be0[b]) mem0[sa0[5:0]][8*b +: 8] <= wd0[8*b +: 8];
    rd0 <= mem0[sa0[5:0]];
  end

  typedef struct { logic err; logic [31:0] ld; int cyc; } resp_t;
  typedef struct { logic we; logic [3:0] be; logic [13:0] a; logic [31:0] wd; int cyc; } acc_t;
  resp_t rq[$];
  acc_t  aq[$];
  int checks = 0, errors = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT presents a response or access.
  always @(negedge clk) begin
    resp_t r;
    acc_t  x;
    if (rst_l) begin
      if (rdy1) begin
        if (rq.size() == 0) flag("unexpected ready");
        else begin
          r = rq.pop_front();
          chk("ready cycle", cyc, r.cyc);
          chk("bus err", {31'b0, err1}, {31'b0, r.err});
          chk("load data", ld1, r.ld);
        end
      end else if (err1) flag("err without ready");
      if (cs1) begin
        if (aq.size() == 0) flag("unexpected sram cs");
        else begin
          x = aq.pop_front();
          chk("cs cycle", cyc, x.cyc);
          chk("sram we", {31'b0, we1}, {31'b0, x.we});
          chk("sram be", {28'b0, be1}, {28'b0, x.be});
          chk("sram addr", {18'b0, sa1}, {18'b0, x.a});
          if (x.we) chk("sram wdata", wd1, x.wd);
        end
      end
    end
  end

  // One transaction on the one-wait-state instance with hand-computed results.
  task automatic req(input logic w, input logic [1:0] s, input logic [15:0] a,
                     input logic [31:0] d, input logic e, input logic [31:0] ld,
                     input int lat, input logic acc, input logic [3:0] be,
                     input logic [31:0] wd);
    resp_t r;
    acc_t  x;
    int    n;
    @(posedge clk); #1;
    en1 = 1'b1; wen1 = w; sz1 = s; ad1 = a; sd1 = d;
    r.err = e; r.ld = ld; r.cyc = cyc + lat;
    rq.push_back(r);
    if (acc) begin
      x.we = w; x.be = be; x.a = a[15:2]; x.wd = wd; x.cyc = cyc + 2;
      aq.push_back(x);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!rdy1 && n < 20);
    if (!rdy1) flag("ready timeout");
    en1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) begin mem1[i] = '0; mem0[i] = '0; end
    rd1 = '0; rd0 = '0;
    en1 = 0; wen1 = 0; sz1 = 0; ad1 = 0; sd1 = 0;
    en0 = 0; wen0 = 0; sz0 = 0; ad0 = 0; sd0 = 0;
    rst_l = 1'b1;
    #2 rst_l = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", {31'b0, rdy1}, 0);
    chk("reset err", {31'b0, err1}, 0);
    chk("reset load", ld1, 0);
    chk("reset cs", {31'b0, cs1}, 0);
    chk("reset we", {31'b0, we1}, 0);
    chk("reset be", {28'b0, be1}, 0);
    chk("reset addr", {18'b0, sa1}, 0);
    chk("reset wdata", wd1, 0);
    chk("reset ws0 ready", {31'b0, rdy0}, 0);
    rst_l = 1'b1;

    req(1, SIZE_W,   16'h0010, 32'hDEADBEEF, 0, 32'h0,        3, 1, 4'hF, 32'hDEADBEEF);
    req(0, SIZE_W,   16'h0010, 32'h0,        0, 32'hDEADBEEF, 4, 1, 4'hF, 32'h0);
    req(1, SIZE_B,   16'h0013, 32'h123456A5, 0, 32'hDEADBEEF, 3, 1, 4'h8, 32'hA5A5A5A5);
    req(0, SIZE_B,   16'h0013, 32'h0,        0, 32'h000000A5, 4, 1, 4'h8, 32'h0);
    req(0, SIZE_H,   16'h0012, 32'h0,        0, 32'h0000A5AD, 4, 1, 4'hC, 32'h0);
    req(0, SIZE_H,   16'h0011, 32'h0,        1, 32'h0,        1, 0, 4'h0, 32'h0);
    req(0, SIZE_RSV, 16'h0010, 32'h0,        1, 32'h0,        1, 0, 4'h0, 32'h0);
    req(0, SIZE_W,   16'h0010, 32'h0,        0, 32'hA5ADBEEF, 4, 1, 4'hF, 32'h0);
    req(1, SIZE_H,   16'h0022, 32'hCAFE1234, 0, 32'hA5ADBEEF, 3, 1, 4'hC, 32'h12341234);
    req(0, SIZE_W,   16'h0020, 32'h0,        0, 32'h12340000, 4, 1, 4'hF, 32'h0);
    req(1, SIZE_W,   16'h0002, 32'h55555555, 1, 32'h12340000, 1, 0, 4'h0, 32'h0);
    req(0, SIZE_B,   16'h0022, 32'h0,        0, 32'h00000034, 4, 1, 4'h4, 32'h0);

    // Reset while the request sits in WAIT.
    @(posedge clk); #1;
    en1 = 1; wen1 = 1; sz1 = SIZE_W; ad1 = 16'h0030; sd1 = 32'h11111111;
    @(posedge clk); #1;
    rst_l = 1'b0; #1;
    en1 = 0;
    chk("wait abort cs", {31'b0, cs1}, 0);
    chk("wait abort ready", {31'b0, rdy1}, 0);
    chk("wait abort load", ld1, 0);
    repeat (2) @(posedge clk);
    #1 rst_l = 1'b1;

    // Reset while the SRAM strobe is up: it must fall without a clock edge.
    @(posedge clk); #1;
    en1 = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("access cs up", {31'b0, cs1}, 1);
    rst_l = 1'b0; #1;
    en1 = 0;
    chk("access abort cs", {31'b0, cs1}, 0);
    chk("access abort we", {31'b0, we1}, 0);
    chk("access abort be", {28'b0, be1}, 0);
    repeat (2) @(posedge clk);
    #1 rst_l = 1'b1;
    chk("aborted write absent", mem1[12], 0);

    req(1, SIZE_W, 16'h0030, 32'h0BADF00D, 0, 32'h0,        3, 1, 4'hF, 32'h0BADF00D);
    req(0, SIZE_W, 16'h0030, 32'h0,        0, 32'h0BADF00D, 4, 1, 4'hF, 32'h0);

    // Zero wait states, request held high: one access every 3 cycles.
    @(posedge clk); #1;
    en0 = 1; wen0 = 1; sz0 = SIZE_W; ad0 = 16'h0000; sd0 = 32'h100;
    begin
      int k;
      k = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        chk("ws0 cs", {31'b0, cs0}, {31'b0, ((i % 3) == 1) && (i <= 7)});
        chk("ws0 ready", {31'b0, rdy0}, {31'b0, ((i % 3) == 2) && (i <= 8)});
        if (rdy0) begin
          k++;
          if (k < 3) begin ad0 = 16'(4 * k); sd0 = 32'h100 + 32'(k); end
          else en0 = 0;
        end
      end
    end
    chk("ws0 mem0", mem0[0], 32'h100);
    chk("ws0 mem1", mem0[1], 32'h101);
    chk("ws0 mem2", mem0[2], 32'h102);
    chk("ws0 mem3", mem0[3], 32'h0);

    repeat (4) @(posedge clk);
    chk("pending responses", rq.size(), 0);
    chk("pending accesses", aq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
